multicycle_ctrl: RTL and testbench

//  Multicycle sequencer for the MIPS-subset core. Steps each instruction through fetch/decode/execute/memory/writeback
//  on a shared ALU and a single instruction/data memory port with a req/ready handshake.

---
 rtl/multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer for the MIPS-subset core: steps each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
module multicycle_ctrl #(
  parameter int WAIT_MAX = 255,
  parameter bit TRAP_ILL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext,
  output logic [1:0] alu_op,
  output logic       status_n,
  output logic       trap,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_EXEC_R = 4'h2,
    S_WB_R   = 4'h3,
    S_ADDR   = 4'h4,
    S_MEM_RD = 4'h5,
    S_WB_LW  = 4'h6,
    S_MEM_WR = 4'h7,
    S_BRANCH = 4'h8,
    S_EXEC_I = 4'h9,
    S_WB_I   = 4'hA,
    S_JUMP   = 4'hB,
    S_JMS_RD = 4'hC,
    S_RST    = 4'hE,
    S_TRAP   = 4'hF
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_JRS   = 6'b010010;
  localparam logic [5:0] OP_BALN  = 6'b011011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JMSUB = 6'b100010;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       mem_state;
  logic       timeout;

  // Memory-access states are decoded from the state alone so the timeout path
  // does not loop back through the output logic.
  assign mem_state = (state_q == S_FETCH)  || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR) || (state_q == S_JMS_RD);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_RST;
      status_n <= 1'b0;
      trap     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP)
        trap <= 1'b1;
      if (state_q == S_WB_R)
        status_n <= alu_neg;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // NOTE: every output and state_d gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext        = 2'd0;
    alu_op     = 2'd0;
    instr_done = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:       state_d = (funct == FN_JMSUB) ? S_JMS_RD : S_EXEC_R;
          OP_LW, OP_SW:   state_d = S_ADDR;
          OP_BEQ, OP_BLTZ: state_d = S_BRANCH;
          OP_ORI:         state_d = S_EXEC_I;
          OP_JRS, OP_BALN: state_d = S_JUMP;
          default: begin
            if (TRAP_ILL) begin
              state_d = S_TRAP;
            end else begin
              state_d    = S_FETCH;
              instr_done = 1'b1;
            end
          end
        endcase
      end

      // The ALU controls stay applied through writeback so alu_neg still
      // reflects the R-type result when status_n captures it.
      S_EXEC_R, S_WB_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        if (funct == FN_SLL) begin
          alu_src_b = 2'd2;
          ext       = 2'b10;
        end
        if (state_q == S_WB_R) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_WB_R;
        end
      end

      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)
          state_d = S_WB_LW;
      end

      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      // bltz encodes rt=$0, so rs-rt with the rt source yields rs-0.
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
        if (((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BLTZ) && alu_neg)) begin
          pc_write = 1'b1;
          pc_src   = 2'd1;
        end
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext       = 2'b01;
        alu_op    = 2'b11;
        state_d   = S_WB_I;
      end

      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        instr_done = 1'b1;
        state_d    = S_FETCH;
        if (opcode == OP_JRS) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end else if (status_n) begin
          pc_write   = 1'b1;
          pc_src     = 2'd1;
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
      end

      S_JMS_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          pc_write   = 1'b1;
          pc_src     = 2'd3;
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_TRAP;
    endcase

    if (timeout)
      state_d = S_TRAP;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full control word against hand-built expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       alu_neg = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic       alu_src_a, status_n, trap, instr_done;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, ext, alu_op;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext(ext), .alu_op(alu_op), .status_n(status_n),
    .trap(trap), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, ext, alu_op;
    logic       instr_done;
  } ctrl_t;

  localparam ctrl_t ALL = '1;

  ctrl_t act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext, alu_op, instr_done};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t m_noalu();
    ctrl_t m = ALL;
    m.alu_src_a = 1'b0; m.alu_src_b = '0; m.ext = '0; m.alu_op = '0;
    return m;
  endfunction

  function automatic ctrl_t e_none();
    ctrl_t e = '0;
    return e;
  endfunction

  function automatic ctrl_t e_fetch(input logic r);
    ctrl_t e = '0;
    e.mem_req = 1'b1; e.alu_src_b = 2'd1;
    if (r) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
    return e;
  endfunction

  function automatic ctrl_t e_decode();
    ctrl_t e = '0;
    e.alu_src_b = 2'd3;
    return e;
  endfunction

  function automatic ctrl_t e_exec_r(input logic sll);
    ctrl_t e = '0;
    e.alu_src_a = 1'b1; e.alu_op = 2'b10;
    if (sll) begin e.alu_src_b = 2'd2; e.ext = 2'b10; end
    return e;
  endfunction

  function automatic ctrl_t e_wb_r();
    ctrl_t e = '0;
    e.reg_write = 1'b1; e.reg_dst = 2'd1; e.instr_done = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t e_addr();
    ctrl_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    return e;
  endfunction

  function automatic ctrl_t e_memrd();
    ctrl_t e = '0;
    e.mem_req = 1'b1; e.iord = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t e_wb_lw();
    ctrl_t e = '0;
    e.reg_write = 1'b1; e.mem_to_reg = 2'd1; e.instr_done = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t e_memwr(input logic r);
    ctrl_t e = '0;
    e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; e.instr_done = r;
    return e;
  endfunction

  function automatic ctrl_t e_branch(input logic tk);
    ctrl_t e = '0;
    e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.instr_done = 1'b1;
    if (tk) begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
    return e;
  endfunction

  function automatic ctrl_t e_exec_i();
    ctrl_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.ext = 2'b01; e.alu_op = 2'b11;
    return e;
  endfunction

  function automatic ctrl_t e_wb_i();
    ctrl_t e = '0;
    e.reg_write = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t e_jrs();
    ctrl_t e = '0;
    e.pc_write = 1'b1; e.pc_src = 2'd2; e.instr_done = 1'b1;
    return e;
  endfunction

  function automatic ctrl_t e_baln(input logic t);
    ctrl_t e = '0;
    e.instr_done = 1'b1;
    if (t) begin
      e.pc_write = 1'b1; e.pc_src = 2'd1; e.reg_write = 1'b1;
      e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
    end
    return e;
  endfunction

  function automatic ctrl_t e_jms(input logic r);
    ctrl_t e = '0;
    e.mem_req = 1'b1; e.iord = 1'b1;
    if (r) begin
      e.pc_write = 1'b1; e.pc_src = 2'd3; e.reg_write = 1'b1;
      e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; e.instr_done = 1'b1;
    end
    return e;
  endfunction

  // Called 1 time unit after a rising edge: drive mem_ready, compare, then
  // move to 1 time unit after the next rising edge.
  task automatic cyc(input string tag, input logic rdy, input ctrl_t exp, input ctrl_t mask);
    mem_ready = rdy;
    #1;
    check(tag, 32'(act & mask), 32'(exp & mask));
    @(posedge clk);
    #1;
  endtask

  task automatic run_rtype(input string tag, input logic [5:0] fn, input logic neg);
    opcode = 6'b000000; funct = fn; alu_neg = neg;
    cyc({tag, "_fetch"}, 1'b1, e_fetch(1'b1), ALL);
    cyc({tag, "_decode"}, 1'b0, e_decode(), ALL);
    cyc({tag, "_exec"}, 1'b0, e_exec_r(fn == 6'b000000), ALL);
    cyc({tag, "_wb"}, 1'b0, e_wb_r(), m_noalu());
    check({tag, "_status_n"}, 32'(status_n), 32'(neg));
    alu_neg = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'(act), 32'(e_none()));
    check("rst_status_n", 32'(status_n), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_idle", 32'(act), 32'(e_none()));
    @(posedge clk);
    #1;

    // add, ready immediately: four cycles, write only in WB_R
    run_rtype("add", 6'b100000, 1'b0);

    // lw with three wait cycles in FETCH and in MEM_RD: 11 cycles
    opcode = 6'b100011;
    for (int i = 0; i < 3; i++) cyc("lw_fetch_wait", 1'b0, e_fetch(1'b0), ALL);
    cyc("lw_fetch_rdy", 1'b1, e_fetch(1'b1), ALL);
    cyc("lw_decode_stray_ready", 1'b1, e_decode(), ALL);
    cyc("lw_addr", 1'b0, e_addr(), ALL);
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b0, e_memrd(), ALL);
    cyc("lw_memrd_rdy", 1'b1, e_memrd(), ALL);
    cyc("lw_wb", 1'b0, e_wb_lw(), ALL);

    // beq taken / not taken, bltz taken
    opcode = 6'b000100; alu_zero = 1'b1;
    cyc("beq_t_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("beq_t_decode", 1'b0, e_decode(), ALL);
    cyc("beq_t_branch", 1'b0, e_branch(1'b1), ALL);
    alu_zero = 1'b0;
    cyc("beq_n_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("beq_n_decode", 1'b0, e_decode(), ALL);
    cyc("beq_n_branch", 1'b0, e_branch(1'b0), ALL);
    opcode = 6'b000001; alu_neg = 1'b1;
    cyc("bltz_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("bltz_decode", 1'b0, e_decode(), ALL);
    cyc("bltz_branch", 1'b0, e_branch(1'b1), ALL);
    alu_neg = 1'b0;

    // ori, sw (ready immediately), jrs, jmsub with one wait cycle
    opcode = 6'b001101;
    cyc("ori_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("ori_decode", 1'b0, e_decode(), ALL);
    cyc("ori_exec", 1'b0, e_exec_i(), ALL);
    cyc("ori_wb", 1'b0, e_wb_i(), ALL);
    opcode = 6'b101011;
    cyc("sw_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("sw_decode", 1'b0, e_decode(), ALL);
    cyc("sw_addr", 1'b0, e_addr(), ALL);
    cyc("sw_memwr_rdy", 1'b1, e_memwr(1'b1), ALL);
    opcode = 6'b010010;
    cyc("jrs_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("jrs_decode", 1'b0, e_decode(), ALL);
    cyc("jrs_jump", 1'b0, e_jrs(), ALL);
    opcode = 6'b000000; funct = 6'b100010;
    cyc("jms_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("jms_decode", 1'b0, e_decode(), ALL);
    cyc("jms_wait", 1'b0, e_jms(1'b0), ALL);
    cyc("jms_rdy", 1'b1, e_jms(1'b1), ALL);

    // sll with negative result sets N, baln then links; clear N, baln idles
    run_rtype("sll_neg", 6'b000000, 1'b1);
    opcode = 6'b011011;
    cyc("baln_t_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("baln_t_decode", 1'b0, e_decode(), ALL);
    cyc("baln_t_jump", 1'b0, e_baln(1'b1), ALL);
    check("baln_t_status_kept", 32'(status_n), 32'd1);
    run_rtype("add_pos", 6'b100000, 1'b0);
    opcode = 6'b011011;
    cyc("baln_n_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("baln_n_decode", 1'b0, e_decode(), ALL);
    cyc("baln_n_jump", 1'b0, e_baln(1'b0), ALL);

    // Reset while a store waits for memory
    run_rtype("add_neg", 6'b100000, 1'b1);
    opcode = 6'b101011;
    cyc("swr_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("swr_decode", 1'b0, e_decode(), ALL);
    cyc("swr_addr", 1'b0, e_addr(), ALL);
    cyc("swr_wait", 1'b0, e_memwr(1'b0), ALL);
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    check("swr_wait_rst_low", 32'(act), 32'(e_memwr(1'b0)));
    @(posedge clk);
    #1;
    check("swr_rst_outputs", 32'(act), 32'(e_none()));
    check("swr_rst_status_n", 32'(status_n), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Illegal opcode traps; memory never requested again
    opcode = 6'b111111;
    cyc("ill_fetch", 1'b1, e_fetch(1'b1), ALL);
    cyc("ill_decode", 1'b0, e_decode(), ALL);
    check("ill_trap_set", 32'(trap), 32'd1);
    for (int i = 0; i < 3; i++) cyc("ill_trap_idle", 1'b1, e_none(), ALL);
    check("ill_trap_sticky", 32'(trap), 32'd1);

    // Reset clears trap, then mem_ready low for 255 cycles times out
    rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_trap_clear", 32'(trap), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 254; i++) begin
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
    end
    check("to_cycle255_still_fetch", 32'(act), 32'(e_fetch(1'b0)));
    check("to_cycle255_no_trap", 32'(trap), 32'd0);
    @(posedge clk);
    #1;
    check("to_trap_outputs", 32'(act), 32'(e_none()));
    check("to_trap_set", 32'(trap), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
